// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace recorder: state encoding, entry layout, sizing helpers.
package cpu_trace_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 2'd0,
        ST_PRETRIG  = 2'd1,
        ST_POSTTRIG = 2'd2,
        ST_DONE     = 2'd3
    } trace_state_t;

    // Entry layout, LSB first: halt, flags, y, x, acc, pc, wr, rd, data, addr
    typedef enum int unsigned {
        F_HALT, F_FLAGS, F_Y, F_X, F_ACC, F_PC, F_WR, F_RD, F_DATA, F_ADDR
    } field_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < value) w++;
        return w;
    endfunction

    function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw);
        return 2 * aw + 5 * dw + 3;
    endfunction

    function automatic int unsigned field_off(input field_e f, input int unsigned aw,
                                              input int unsigned dw);
        case (f)
            F_HALT:  return 0;
            F_FLAGS: return 1;
            F_Y:     return 1 + dw;
            F_X:     return 1 + 2 * dw;
            F_ACC:   return 1 + 3 * dw;
            F_PC:    return 1 + 4 * dw;
            F_WR:    return 1 + 4 * dw + aw;
            F_RD:    return 2 + 4 * dw + aw;
            F_DATA:  return 3 + 4 * dw + aw;
            default: return 3 + 5 * dw + aw;
        endcase
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_if.sv
// Control, observation and readout signals of the trace recorder.
interface cpu_trace_buffer_if
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned IDX_W   = clog2(DEPTH);
    localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);

    logic                 arm;
    logic                 abort;
    logic                 trig_pc_en;
    logic [ADDR_W-1:0]    trig_pc_match;
    logic [ADDR_W-1:0]    trig_pc_mask;
    logic                 trig_ext;
    logic [ADDR_W-1:0]    addr_bus;
    logic [DATA_W-1:0]    data_bus;
    logic                 mem_read;
    logic                 mem_write;
    logic [ADDR_W-1:0]    pc;
    logic [DATA_W-1:0]    acc;
    logic [DATA_W-1:0]    x;
    logic [DATA_W-1:0]    y;
    logic [DATA_W-1:0]    flags;
    logic                 halt;
    logic                 rd_req;
    logic [IDX_W-1:0]     rd_idx;
    logic                 rd_valid;
    logic [ENTRY_W-1:0]   rd_entry;
    logic [STATE_W-1:0]   state;
    logic [IDX_W:0]       count;
    logic [IDX_W-1:0]     trig_pos;

    modport master (
        output arm, abort, trig_pc_en, trig_pc_match, trig_pc_mask, trig_ext,
               addr_bus, data_bus, mem_read, mem_write, pc, acc, x, y, flags, halt,
               rd_req, rd_idx,
        input  rd_valid, rd_entry, state, count, trig_pos
    );

    modport slave (
        input  arm, abort, trig_pc_en, trig_pc_match, trig_pc_mask, trig_ext,
               addr_bus, data_bus, mem_read, mem_write, pc, acc, x, y, flags, halt,
               rd_req, rd_idx,
        output rd_valid, rd_entry, state, count, trig_pos
    );
endinterface

// File: rtl/trace_ram.sv
// Simple dual-port trace storage with registered read, shaped for block-RAM inference.
module trace_ram
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular trace recorder: captures CPU observation signals until a trigger plus a
// programmable post-trigger window, then freezes for indexed readout.
module cpu_trace_buffer
    import cpu_trace_pkg::*;
#(
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned POST_TRIG    = 32,
    parameter int unsigned CAPTURE_MODE = 0
) (
    input logic               clk,
    input logic               reset,
    cpu_trace_buffer_if.slave bus
);
    localparam int unsigned IDX_W   = clog2(DEPTH);
    localparam int unsigned CNT_W   = IDX_W + 1;
    localparam int unsigned ENTRY_W = entry_w(ADDR_W, DATA_W);
    localparam int unsigned O_HALT  = field_off(F_HALT,  ADDR_W, DATA_W);
    localparam int unsigned O_FLAGS = field_off(F_FLAGS, ADDR_W, DATA_W);
    localparam int unsigned O_Y     = field_off(F_Y,     ADDR_W, DATA_W);
    localparam int unsigned O_X     = field_off(F_X,     ADDR_W, DATA_W);
    localparam int unsigned O_ACC   = field_off(F_ACC,   ADDR_W, DATA_W);
    localparam int unsigned O_PC    = field_off(F_PC,    ADDR_W, DATA_W);
    localparam int unsigned O_WR    = field_off(F_WR,    ADDR_W, DATA_W);
    localparam int unsigned O_RD    = field_off(F_RD,    ADDR_W, DATA_W);
    localparam int unsigned O_DATA  = field_off(F_DATA,  ADDR_W, DATA_W);
    localparam int unsigned O_ADDR  = field_off(F_ADDR,  ADDR_W, DATA_W);

    trace_state_t      state_q, state_d;
    logic [IDX_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  trig_addr_q, trig_addr_d;
    logic [IDX_W-1:0]  post_cnt_q, post_cnt_d;
    logic [IDX_W-1:0]  trig_pos_q, trig_pos_d;
    logic [ADDR_W-1:0] last_pc_q, last_pc_d;
    logic              halt_q;
    logic              rd_valid_q;
    logic              show_q;

    logic               trig_hit, qualify, store;
    logic               rd_ok, rd_oob;
    logic [IDX_W-1:0]   oldest, raddr;
    logic [ENTRY_W-1:0] wr_entry, ram_rdata;

    assign trig_hit = (bus.trig_pc_en &&
                       (((bus.pc ^ bus.trig_pc_match) & bus.trig_pc_mask) == '0))
                    || bus.trig_ext || (bus.halt && !halt_q);
    // In change-only mode the first sample after arm always qualifies (nothing stored yet)
    assign qualify  = (CAPTURE_MODE == 0) || (count_q == '0) ||
                      (bus.pc != last_pc_q) || bus.mem_write;

    always_comb begin
        wr_entry                    = '0;
        wr_entry[O_HALT]            = bus.halt;
        wr_entry[O_FLAGS +: DATA_W] = bus.flags;
        wr_entry[O_Y     +: DATA_W] = bus.y;
        wr_entry[O_X     +: DATA_W] = bus.x;
        wr_entry[O_ACC   +: DATA_W] = bus.acc;
        wr_entry[O_PC    +: ADDR_W] = bus.pc;
        wr_entry[O_WR]              = bus.mem_write;
        wr_entry[O_RD]              = bus.mem_read;
        wr_entry[O_DATA  +: DATA_W] = bus.data_bus;
        wr_entry[O_ADDR  +: ADDR_W] = bus.addr_bus;
    end

    // Next-state, pointer and trigger bookkeeping
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wrapped_d   = wrapped_q;
        count_d     = count_q;
        trig_addr_d = trig_addr_q;
        post_cnt_d  = post_cnt_q;
        trig_pos_d  = trig_pos_q;
        last_pc_d   = last_pc_q;
        store       = 1'b0;

        if (bus.arm) begin
            state_d    = ST_PRETRIG;
            wr_ptr_d   = '0;
            count_d    = '0;
            wrapped_d  = 1'b0;
            trig_pos_d = '0;
        end else if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_PRETRIG: begin
                    store = qualify || trig_hit;
                    if (trig_hit) begin
                        trig_addr_d = wr_ptr_q;
                        if (POST_TRIG == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d    = ST_POSTTRIG;
                            post_cnt_d = IDX_W'(POST_TRIG);
                        end
                    end
                end
                ST_POSTTRIG: begin
                    if (qualify) begin
                        store      = 1'b1;
                        post_cnt_d = post_cnt_q - IDX_W'(1);
                        if (post_cnt_q == IDX_W'(1)) state_d = ST_DONE;
                    end
                end
                default: ;
            endcase
        end

        if (store) begin
            wr_ptr_d  = wr_ptr_q + IDX_W'(1);
            last_pc_d = bus.pc;
            if (wr_ptr_q == IDX_W'(DEPTH - 1)) wrapped_d = 1'b1;
            if (count_q != CNT_W'(DEPTH))      count_d   = count_q + CNT_W'(1);
        end

        // Trigger position is fixed once, from the final pointer state on entry to DONE
        if (state_d == ST_DONE && state_q != ST_DONE)
            trig_pos_d = trig_addr_d - (wrapped_d ? wr_ptr_d : '0);
    end

    assign oldest = wrapped_q ? wr_ptr_q : '0;
    assign raddr  = oldest + bus.rd_idx;
    assign rd_ok  = bus.rd_req && (state_q == ST_DONE);
    assign rd_oob = {1'b0, bus.rd_idx} >= count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            wrapped_q   <= 1'b0;
            count_q     <= '0;
            trig_addr_q <= '0;
            post_cnt_q  <= '0;
            trig_pos_q  <= '0;
            last_pc_q   <= '0;
            halt_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            show_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wrapped_q   <= wrapped_d;
            count_q     <= count_d;
            trig_addr_q <= trig_addr_d;
            post_cnt_q  <= post_cnt_d;
            trig_pos_q  <= trig_pos_d;
            last_pc_q   <= last_pc_d;
            halt_q      <= bus.halt;
            rd_valid_q  <= rd_ok;
            if (rd_ok) show_q <= !rd_oob;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (store),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .re    (rd_ok && !rd_oob),
        .raddr (raddr),
        .rdata (ram_rdata)
    );

    // RAM output has no reset; the gate gives zero after reset and for out-of-range reads
    assign bus.rd_entry = show_q ? ram_rdata : '0;
    assign bus.rd_valid = rd_valid_q;
    assign bus.state    = state_q;
    assign bus.count    = count_q;
    assign bus.trig_pos = trig_pos_q;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: three instances (8/64/16 deep) share one stimulus stream.
module tb_cpu_trace_buffer;
    import cpu_trace_pkg::*;

    localparam int unsigned EW = 75;
    typedef logic [EW-1:0] w_t;

    typedef struct {
        logic [1:0]  sel;
        logic        arm, abort, trig_ext, halt, mem_write;
        logic [15:0] pc;
        logic [1:0]  exp_state;
        logic [6:0]  exp_count;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  sel;
    logic        arm, abort, trig_pc_en, trig_ext, halt, mem_write, rd_req;
    logic [15:0] trig_pc_match, trig_pc_mask, pc;
    logic [5:0]  rd_idx;

    logic [1:0]  cur_state;
    logic [6:0]  cur_count;
    logic [5:0]  cur_tpos;
    logic        cur_valid;
    w_t          cur_entry;

    int   checks = 0;
    int   errors = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    cpu_trace_buffer_if #(.DEPTH(8),  .ADDR_W(16), .DATA_W(8)) if8 ();
    cpu_trace_buffer_if #(.DEPTH(64), .ADDR_W(16), .DATA_W(8)) if64 ();
    cpu_trace_buffer_if #(.DEPTH(16), .ADDR_W(16), .DATA_W(8)) ifm ();

    cpu_trace_buffer #(.DEPTH(8), .ADDR_W(16), .DATA_W(8), .POST_TRIG(2), .CAPTURE_MODE(0))
        u8 (.clk(clk), .reset(reset), .bus(if8));
    cpu_trace_buffer #(.DEPTH(64), .ADDR_W(16), .DATA_W(8), .POST_TRIG(0), .CAPTURE_MODE(0))
        u64 (.clk(clk), .reset(reset), .bus(if64));
    cpu_trace_buffer #(.DEPTH(16), .ADDR_W(16), .DATA_W(8), .POST_TRIG(3), .CAPTURE_MODE(1))
        um (.clk(clk), .reset(reset), .bus(ifm));

    // Shared observation buses, all fields derived from pc so entries are predictable
    assign if8.trig_pc_en = trig_pc_en;   assign if64.trig_pc_en = trig_pc_en;   assign ifm.trig_pc_en = trig_pc_en;
    assign if8.trig_pc_match = trig_pc_match; assign if64.trig_pc_match = trig_pc_match; assign ifm.trig_pc_match = trig_pc_match;
    assign if8.trig_pc_mask = trig_pc_mask; assign if64.trig_pc_mask = trig_pc_mask; assign ifm.trig_pc_mask = trig_pc_mask;
    assign if8.trig_ext = trig_ext;       assign if64.trig_ext = trig_ext;       assign ifm.trig_ext = trig_ext;
    assign if8.addr_bus = pc ^ 16'hA000;  assign if64.addr_bus = pc ^ 16'hA000;  assign ifm.addr_bus = pc ^ 16'hA000;
    assign if8.data_bus = pc[7:0] + 8'd1; assign if64.data_bus = pc[7:0] + 8'd1; assign ifm.data_bus = pc[7:0] + 8'd1;
    assign if8.mem_read = pc[0];          assign if64.mem_read = pc[0];          assign ifm.mem_read = pc[0];
    assign if8.mem_write = mem_write;     assign if64.mem_write = mem_write;     assign ifm.mem_write = mem_write;
    assign if8.pc = pc;                   assign if64.pc = pc;                   assign ifm.pc = pc;
    assign if8.acc = pc[7:0] ^ 8'h11;     assign if64.acc = pc[7:0] ^ 8'h11;     assign ifm.acc = pc[7:0] ^ 8'h11;
    assign if8.x = pc[7:0] + 8'h22;       assign if64.x = pc[7:0] + 8'h22;       assign ifm.x = pc[7:0] + 8'h22;
    assign if8.y = ~pc[7:0];              assign if64.y = ~pc[7:0];              assign ifm.y = ~pc[7:0];
    assign if8.flags = {pc[3:0], 4'h9};   assign if64.flags = {pc[3:0], 4'h9};   assign ifm.flags = {pc[3:0], 4'h9};
    assign if8.halt = halt;               assign if64.halt = halt;               assign ifm.halt = halt;
    assign if8.arm = arm && (sel == 2'd0);     assign if64.arm = arm && (sel == 2'd1);     assign ifm.arm = arm && (sel == 2'd2);
    assign if8.abort = abort && (sel == 2'd0); assign if64.abort = abort && (sel == 2'd1); assign ifm.abort = abort && (sel == 2'd2);
    assign if8.rd_req = rd_req && (sel == 2'd0); assign if64.rd_req = rd_req && (sel == 2'd1); assign ifm.rd_req = rd_req && (sel == 2'd2);
    assign if8.rd_idx = rd_idx[2:0];      assign if64.rd_idx = rd_idx;           assign ifm.rd_idx = rd_idx[3:0];

    always_comb begin
        cur_state = if8.state;
        cur_count = 7'(if8.count);
        cur_tpos  = 6'(if8.trig_pos);
        cur_valid = if8.rd_valid;
        cur_entry = if8.rd_entry;
        case (sel)
            2'd1: begin
                cur_state = if64.state; cur_count = 7'(if64.count); cur_tpos = 6'(if64.trig_pos);
                cur_valid = if64.rd_valid; cur_entry = if64.rd_entry;
            end
            2'd2: begin
                cur_state = ifm.state; cur_count = 7'(ifm.count); cur_tpos = 6'(ifm.trig_pos);
                cur_valid = ifm.rd_valid; cur_entry = ifm.rd_entry;
            end
            default: ;
        endcase
    end

    // Reference entry: {addr,data,rd,wr,pc,acc,x,y,flags,halt}
    function automatic w_t f_entry(input logic [15:0] p, input logic w, input logic h);
        logic [7:0] lo;
        lo = p[7:0];
        return {p ^ 16'hA000, lo + 8'd1, p[0], w, p, lo ^ 8'h11, lo + 8'h22, ~lo, {p[3:0], 4'h9}, h};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input int s, input int a, input int ab, input int te, input int h,
                       input int mw, input int p, input int es, input int ec);
        vec_t v;
        v.sel = 2'(s); v.arm = (a != 0); v.abort = (ab != 0); v.trig_ext = (te != 0);
        v.halt = (h != 0); v.mem_write = (mw != 0); v.pc = 16'(p);
        v.exp_state = 2'(es); v.exp_count = 7'(ec);
        vq.push_back(v);
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            sel = vq[i].sel; arm = vq[i].arm; abort = vq[i].abort; trig_ext = vq[i].trig_ext;
            halt = vq[i].halt; mem_write = vq[i].mem_write; pc = vq[i].pc;
            step();
            chk($sformatf("%s[%0d].state", tag, i), w_t'(cur_state), w_t'(vq[i].exp_state));
            chk($sformatf("%s[%0d].count", tag, i), w_t'(cur_count), w_t'(vq[i].exp_count));
        end
        arm = 1'b0; abort = 1'b0; trig_ext = 1'b0; mem_write = 1'b0;
        vq.delete();
    endtask

    // Requests stay asserted across calls, so consecutive calls are back-to-back reads
    task automatic rd_check(input string tag, input int idx, input logic ev, input w_t ee);
        rd_idx = 6'(idx);
        rd_req = 1'b1;
        step();
        chk($sformatf("%s.valid", tag), w_t'(cur_valid), w_t'(ev));
        chk($sformatf("%s.entry", tag), cur_entry, ee);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; sel = 2'd0; arm = 1'b0; abort = 1'b0; trig_pc_en = 1'b0;
        trig_pc_match = '0; trig_pc_mask = '0; trig_ext = 1'b0; halt = 1'b0;
        mem_write = 1'b0; rd_req = 1'b0; rd_idx = '0; pc = '0;
        repeat (2) step();
        reset = 1'b1;
        step();
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("rst%0d.state", s), w_t'(cur_state), w_t'(0));
            chk($sformatf("rst%0d.count", s), w_t'(cur_count), w_t'(0));
            chk($sformatf("rst%0d.tpos",  s), w_t'(cur_tpos),  w_t'(0));
            chk($sformatf("rst%0d.valid", s), w_t'(cur_valid), w_t'(0));
            chk($sformatf("rst%0d.entry", s), cur_entry, w_t'(0));
        end

        // Reset in the middle of PRETRIG
        sel = 2'd1; arm = 1'b1; step(); arm = 1'b0;
        for (int k = 0; k < 10; k++) begin pc = 16'(16'h50 + k); step(); end
        chk("midrst.pre_state", w_t'(cur_state), w_t'(1));
        chk("midrst.pre_count", w_t'(cur_count), w_t'(10));
        reset = 1'b0;
        step();
        chk("midrst.state", w_t'(cur_state), w_t'(0));
        chk("midrst.count", w_t'(cur_count), w_t'(0));
        chk("midrst.valid", w_t'(cur_valid), w_t'(0));
        reset = 1'b1;
        step();
        rd_req = 1'b1; rd_idx = '0;
        step();
        chk("idle_rd.valid", w_t'(cur_valid), w_t'(0));
        rd_req = 1'b0;

        // PC trigger with wrap, DEPTH 8, POST_TRIG 2
        trig_pc_en = 1'b1; trig_pc_match = 16'h0006; trig_pc_mask = 16'hFFFF;
        add(0,1,0,0,0,0,'h00, 1,0);
        add(0,0,0,0,0,0,'h00, 1,1); add(0,0,0,0,0,0,'h01, 1,2); add(0,0,0,0,0,0,'h02, 1,3);
        add(0,0,0,0,0,0,'h03, 1,4); add(0,0,0,0,0,0,'h04, 1,5); add(0,0,0,0,0,0,'h05, 1,6);
        add(0,0,0,0,0,0,'h06, 2,7); add(0,0,0,0,0,0,'h07, 2,8); add(0,0,0,0,0,0,'h08, 3,8);
        add(0,0,0,0,0,0,'h09, 3,8); add(0,0,0,0,0,0,'h0A, 3,8);
        run_table("pctrig");
        trig_pc_en = 1'b0; trig_pc_mask = '0;
        chk("pctrig.tpos", w_t'(cur_tpos), w_t'(5));
        for (int i = 0; i < 8; i++)
            rd_check($sformatf("pctrig.rd%0d", i), i, 1'b1, f_entry(16'(i + 1), 1'b0, 1'b0));
        rd_req = 1'b0;
        step();
        chk("pctrig.rd_idle", w_t'(cur_valid), w_t'(0));

        // External trigger with POST_TRIG 0, DEPTH 64
        add(1,1,0,0,0,0,'h30, 1,0); add(1,0,0,0,0,0,'h30, 1,1); add(1,0,0,0,0,0,'h31, 1,2);
        add(1,0,0,0,0,0,'h32, 1,3); add(1,0,0,1,0,0,'h33, 3,4); add(1,0,0,0,0,0,'h34, 3,4);
        run_table("ext");
        chk("ext.tpos", w_t'(cur_tpos), w_t'(3));
        rd_check("ext.rd0", 0, 1'b1, f_entry(16'h30, 1'b0, 1'b0));
        rd_check("ext.rd3", 3, 1'b1, f_entry(16'h33, 1'b0, 1'b0));
        rd_check("ext.rd4", 4, 1'b1, '0);
        rd_req = 1'b0;

        // arm beats a simultaneous trigger while in DONE
        add(1,1,0,1,0,0,'h40, 1,0); add(1,0,0,0,0,0,'h41, 1,1); add(1,0,0,1,0,0,'h42, 3,2);
        run_table("armtrig");
        chk("armtrig.tpos", w_t'(cur_tpos), w_t'(1));
        rd_check("armtrig.rd1", 1, 1'b1, f_entry(16'h42, 1'b0, 1'b0));
        rd_req = 1'b0;

        // Change-only capture, DEPTH 16, POST_TRIG 3
        add(2,1,0,0,0,0,'h10, 1,0);
        add(2,0,0,0,0,0,'h10, 1,1); add(2,0,0,0,0,0,'h10, 1,1); add(2,0,0,0,0,0,'h10, 1,1);
        add(2,0,0,0,0,0,'h10, 1,1); add(2,0,0,0,0,0,'h10, 1,1);
        add(2,0,0,0,0,0,'h11, 1,2); add(2,0,0,0,0,1,'h11, 1,3); add(2,0,0,0,0,0,'h11, 1,3);
        add(2,0,0,1,0,0,'h11, 2,4); add(2,0,0,0,0,0,'h11, 2,4); add(2,0,0,0,0,0,'h12, 2,5);
        add(2,0,0,0,0,0,'h12, 2,5); add(2,0,0,0,0,0,'h13, 2,6); add(2,0,0,0,0,0,'h14, 3,7);
        add(2,0,0,0,0,0,'h15, 3,7);
        run_table("chg");
        chk("chg.tpos", w_t'(cur_tpos), w_t'(3));
        rd_check("chg.rd0", 0, 1'b1, f_entry(16'h10, 1'b0, 1'b0));
        rd_check("chg.rd1", 1, 1'b1, f_entry(16'h11, 1'b0, 1'b0));
        rd_check("chg.rd2", 2, 1'b1, f_entry(16'h11, 1'b1, 1'b0));
        rd_check("chg.rd3", 3, 1'b1, f_entry(16'h11, 1'b0, 1'b0));
        rd_check("chg.rd6", 6, 1'b1, f_entry(16'h14, 1'b0, 1'b0));
        rd_check("chg.rd7", 7, 1'b1, '0);
        rd_req = 1'b0;

        // halt rising edge triggers once; held halt does not retrigger
        add(0,1,0,0,0,0,'h20, 1,0); add(0,0,0,0,0,0,'h20, 1,1); add(0,0,0,0,0,0,'h21, 1,2);
        add(0,0,0,0,0,0,'h22, 1,3); add(0,0,0,0,1,0,'h23, 2,4); add(0,0,0,0,1,0,'h24, 2,5);
        add(0,0,0,0,1,0,'h25, 3,6); add(0,0,0,0,1,0,'h26, 3,6);
        run_table("halt");
        halt = 1'b0;
        chk("halt.tpos", w_t'(cur_tpos), w_t'(3));
        rd_check("halt.rd2", 2, 1'b1, f_entry(16'h22, 1'b0, 1'b0));
        rd_check("halt.rd3", 3, 1'b1, f_entry(16'h23, 1'b0, 1'b1));
        rd_check("halt.rd5", 5, 1'b1, f_entry(16'h25, 1'b0, 1'b1));
        rd_req = 1'b0;

        // abort returns to IDLE; arm beats a simultaneous abort
        add(0,1,0,0,0,0,'h60, 1,0); add(0,0,0,0,0,0,'h60, 1,1); add(0,0,1,0,0,0,'h61, 0,1);
        add(0,1,1,0,0,0,'h62, 1,0); add(0,0,0,0,0,0,'h62, 1,1); add(0,0,1,0,0,0,'h63, 0,1);
        run_table("abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
